rv_pl_wrapper: RTL and testbench

RV_PL_WRAPPER -- requirements
Module: rv_pl_wrapper

---
 rtl/rv_pl_wrapper.sv | 266 ++++++++++++++++++++++++++
 tb/tb_rv_pl_wrapper.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_pl_wrapper.sv
// Five-stage in-order RV32I subset pipeline (rv_pl) and its memory-facing wrapper.
// Word-addressed instruction/data ports; data memory read is synchronous, result used in W.
package rv_pl_pkg;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
    localparam logic [31:0] HALT_INSTR = 32'h0000_006F;

    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } if_id_t;

    typedef struct packed {
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic        halt;
        logic        alu_src;
        alu_op_e     alu_op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [31:0] pc;
    } id_ex_t;

    typedef struct packed {
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic [4:0]  rd;
        logic [31:0] result;
        logic [31:0] wdata;
    } ex_mem_t;

    typedef struct packed {
        logic        reg_write;
        logic        mem_read;
        logic [4:0]  rd;
        logic [31:0] result;
    } mem_wb_t;
endpackage

module rv_pl
    import rv_pl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] imem_dout,
    input  logic [31:0] dmem_dout,
    output logic [31:0] f_pc,
    output logic        d_mem_write_c,
    output logic        e_mem_write,
    output logic        e_flush_c,
    output logic [31:0] m_alu_result,
    output logic        m_mem_write,
    output logic [31:0] m_write_data,
    output logic        done
);
    logic [31:0] pc_q, pc_d;
    if_id_t      d_q, d_d;
    id_ex_t      e_q, e_d, dec;
    ex_mem_t     m_q, m_d;
    mem_wb_t     w_q, w_d;
    logic        done_q, done_d;
    logic [31:0] rf_q [32];

    logic [31:0] d_ins, w_value, fwd_a, fwd_b, alu_b, alu_y, target;
    logic        w_we, taken, stall;

    assign d_ins   = d_q.instr;
    assign w_we    = w_q.reg_write && (w_q.rd != 5'd0);
    assign w_value = w_q.mem_read ? dmem_dout : w_q.result;

    // Decode; register reads see a same-cycle W write
    always_comb begin
        dec         = '0;
        dec.rs1     = d_ins[19:15];
        dec.rs2     = d_ins[24:20];
        dec.rd      = d_ins[11:7];
        dec.pc      = d_q.pc;
        dec.imm     = {{20{d_ins[31]}}, d_ins[31:20]};
        dec.rs1_val = rf_q[dec.rs1];
        dec.rs2_val = rf_q[dec.rs2];
        if (dec.rs1 == 5'd0)                     dec.rs1_val = '0;
        else if (w_we && (w_q.rd == dec.rs1))    dec.rs1_val = w_value;
        if (dec.rs2 == 5'd0)                     dec.rs2_val = '0;
        else if (w_we && (w_q.rd == dec.rs2))    dec.rs2_val = w_value;
        case (d_ins[6:0])
            7'b0110011: begin
                dec.reg_write = 1'b1;
                case (d_ins[14:12])
                    3'b000:  dec.alu_op = d_ins[30] ? ALU_SUB : ALU_ADD;
                    3'b010:  dec.alu_op = ALU_SLT;
                    3'b110:  dec.alu_op = ALU_OR;
                    3'b111:  dec.alu_op = ALU_AND;
                    default: dec.reg_write = 1'b0;
                endcase
            end
            7'b0010011: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                case (d_ins[14:12])
                    3'b000:  dec.alu_op = ALU_ADD;
                    3'b010:  dec.alu_op = ALU_SLT;
                    3'b110:  dec.alu_op = ALU_OR;
                    3'b111:  dec.alu_op = ALU_AND;
                    default: dec.reg_write = 1'b0;
                endcase
            end
            7'b0000011: if (d_ins[14:12] == 3'b010) begin
                dec.reg_write = 1'b1;
                dec.mem_read  = 1'b1;
                dec.alu_src   = 1'b1;
            end
            7'b0100011: if (d_ins[14:12] == 3'b010) begin
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.imm       = {{20{d_ins[31]}}, d_ins[31:25], d_ins[11:7]};
            end
            7'b1100011: if (d_ins[14:12] == 3'b000) begin
                dec.branch = 1'b1;
                dec.imm    = {{19{d_ins[31]}}, d_ins[31], d_ins[7], d_ins[30:25], d_ins[11:8], 1'b0};
            end
            7'b1101111: begin
                dec.jump      = 1'b1;
                dec.reg_write = 1'b1;
                dec.halt      = (d_ins == HALT_INSTR);
                dec.imm       = {{11{d_ins[31]}}, d_ins[31], d_ins[19:12], d_ins[20], d_ins[30:21], 1'b0};
            end
            default: ;
        endcase
    end

    // Execute: M result beats W result beats the value read in D
    always_comb begin
        fwd_a = e_q.rs1_val;
        fwd_b = e_q.rs2_val;
        if (m_q.reg_write && (m_q.rd != 5'd0) && (m_q.rd == e_q.rs1)) fwd_a = m_q.result;
        else if (w_we && (w_q.rd == e_q.rs1))                          fwd_a = w_value;
        if (m_q.reg_write && (m_q.rd != 5'd0) && (m_q.rd == e_q.rs2)) fwd_b = m_q.result;
        else if (w_we && (w_q.rd == e_q.rs2))                          fwd_b = w_value;
        alu_b = e_q.alu_src ? e_q.imm : fwd_b;
        alu_y = fwd_a + alu_b;
        case (e_q.alu_op)
            ALU_SUB: alu_y = fwd_a - alu_b;
            ALU_AND: alu_y = fwd_a & alu_b;
            ALU_OR:  alu_y = fwd_a | alu_b;
            ALU_SLT: alu_y = {31'b0, ($signed(fwd_a) < $signed(alu_b))};
            default: alu_y = fwd_a + alu_b;
        endcase
        target = e_q.pc + e_q.imm;
        taken  = e_q.jump || (e_q.branch && (fwd_a == fwd_b));
        stall  = e_q.mem_read && (e_q.rd != 5'd0) && ((e_q.rd == dec.rs1) || (e_q.rd == dec.rs2));
    end

    // Pipeline advance; a taken branch overrides a load-use stall
    always_comb begin
        pc_d        = pc_q + 32'd4;
        d_d.instr   = imem_dout;
        d_d.pc      = pc_q;
        e_d         = dec;
        m_d.reg_write = e_q.reg_write;
        m_d.mem_read  = e_q.mem_read;
        m_d.mem_write = e_q.mem_write;
        m_d.rd        = e_q.rd;
        m_d.result    = e_q.jump ? (e_q.pc + 32'd4) : alu_y;
        m_d.wdata     = fwd_b;
        w_d.reg_write = m_q.reg_write;
        w_d.mem_read  = m_q.mem_read;
        w_d.rd        = m_q.rd;
        w_d.result    = m_q.result;
        done_d        = done_q | e_q.halt;
        if (taken) begin
            pc_d      = target;
            d_d.instr = NOP_INSTR;
            d_d.pc    = '0;
            e_d       = '0;
        end else if (stall) begin
            pc_d = pc_q;
            d_d  = d_q;
            e_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            pc_q      <= '0;
            d_q.instr <= NOP_INSTR;
            d_q.pc    <= '0;
            e_q       <= '0;
            m_q       <= '0;
            w_q       <= '0;
            done_q    <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            d_q    <= d_d;
            e_q    <= e_d;
            m_q    <= m_d;
            w_q    <= w_d;
            done_q <= done_d;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else if (w_we) begin
            rf_q[w_q.rd] <= w_value;
        end
    end

    assign f_pc          = pc_q;
    assign d_mem_write_c = dec.mem_write;
    assign e_mem_write   = e_q.mem_write;
    assign e_flush_c     = taken;
    assign m_alu_result  = m_q.result;
    assign m_mem_write   = m_q.mem_write;
    assign m_write_data  = m_q.wdata;
    assign done          = done_q;
endmodule

module rv_pl_wrapper (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_dout,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_we,
    output logic [31:0] dmem_din,
    input  logic [31:0] dmem_dout,
    output logic        done_flag
);
    logic [31:0] f_pc, m_alu_result, m_write_data;
    logic        d_mem_write_c, e_mem_write, e_flush_c, m_mem_write;
    logic        unused_core;

    rv_pl rv_pl (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_dout    (imem_dout),
        .dmem_dout    (dmem_dout),
        .f_pc         (f_pc),
        .d_mem_write_c(d_mem_write_c),
        .e_mem_write  (e_mem_write),
        .e_flush_c    (e_flush_c),
        .m_alu_result (m_alu_result),
        .m_mem_write  (m_mem_write),
        .m_write_data (m_write_data),
        .done         (done_flag)
    );

    // Only a 14-bit byte range is decoded; the rest wraps
    assign imem_addr = {20'b0, f_pc[13:2]};
    assign dmem_addr = {20'b0, m_alu_result[13:2]};
    assign dmem_we   = m_mem_write ? 4'b1111 : 4'b0000;
    assign dmem_din  = m_write_data;

    assign unused_core = ^{f_pc[31:14], f_pc[1:0], m_alu_result[31:14], m_alu_result[1:0],
                           d_mem_write_c, e_mem_write, e_flush_c};
endmodule

// File: tb/tb_rv_pl_wrapper.sv
// Bench for rv_pl_wrapper: directed programs plus random programs checked against an
// instruction-level interpreter of the same program and initial data memory.
module tb_rv_pl_wrapper;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_addr, imem_dout, dmem_addr, dmem_din;
    logic [31:0] dmem_dout = '0;
    logic [3:0]  dmem_we;
    logic        done_flag;
    logic        load_req = 1'b0;

    logic [31:0] prog    [1024];
    logic [31:0] mem     [4096];
    logic [31:0] dinit   [4096];
    logic [31:0] ref_mem [4096];
    int          n_ins;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    rv_pl_wrapper dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .imem_addr(imem_addr),
        .imem_dout(imem_dout),
        .dmem_addr(dmem_addr),
        .dmem_we  (dmem_we),
        .dmem_din (dmem_din),
        .dmem_dout(dmem_dout),
        .done_flag(done_flag)
    );

    assign imem_dout = prog[imem_addr[9:0]];
    wire unused_tb = ^{imem_addr[31:10], dmem_addr[31:12]};

    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < 4096; i++) mem[i] <= dinit[i];
        end else begin
            if (dmem_we == 4'hF) mem[dmem_addr[11:0]] <= dmem_din;
            dmem_dout <= mem[dmem_addr[11:0]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
        return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction
    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [11:0] imm);
        return enc_i(imm, rs1, 3'b000, rd, 7'b0010011);
    endfunction
    function automatic logic [31:0] lw(input logic [4:0] rd, input logic [11:0] off);
        return enc_i(off, 5'd0, 3'b010, rd, 7'b0000011);
    endfunction

    task automatic emit(input logic [31:0] w);
        prog[n_ins] = w;
        n_ins++;
    endtask

    task automatic clear_all();
        for (int i = 0; i < 1024; i++) prog[i] = 32'h0000_0013;
        for (int i = 0; i < 4096; i++) dinit[i] = 32'hFFFF_FFFF;
        n_ins = 0;
    endtask

    // Architectural interpreter: one instruction per step, no pipeline notion
    task automatic model_run();
        logic [31:0] r [32];
        logic [31:0] pc, ins, a, b, ii, is, ib, ij, res, nxt, ea;
        logic        wr;
        for (int i = 0; i < 32; i++) r[i] = '0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = dinit[i];
        pc = '0;
        for (int s = 0; s < 5000; s++) begin
            ins = prog[pc[11:2]];
            if (ins == 32'h0000_006F) break;
            a   = r[ins[19:15]];
            b   = r[ins[24:20]];
            ii  = {{20{ins[31]}}, ins[31:20]};
            is  = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            ib  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            ij  = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            nxt = pc + 32'd4;
            wr  = 1'b0;
            res = '0;
            case (ins[6:0])
                7'h33: begin
                    wr = 1'b1;
                    case (ins[14:12])
                        3'd0:    res = ins[30] ? a - b : a + b;
                        3'd2:    res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                        3'd6:    res = a | b;
                        3'd7:    res = a & b;
                        default: wr = 1'b0;
                    endcase
                end
                7'h13: begin
                    wr = 1'b1;
                    case (ins[14:12])
                        3'd0:    res = a + ii;
                        3'd2:    res = ($signed(a) < $signed(ii)) ? 32'd1 : 32'd0;
                        3'd6:    res = a | ii;
                        3'd7:    res = a & ii;
                        default: wr = 1'b0;
                    endcase
                end
                7'h03: if (ins[14:12] == 3'd2) begin
                    ea  = a + ii;
                    res = ref_mem[ea[13:2]];
                    wr  = 1'b1;
                end
                7'h23: if (ins[14:12] == 3'd2) begin
                    ea = a + is;
                    ref_mem[ea[13:2]] = b;
                end
                7'h63: if ((ins[14:12] == 3'd0) && (a == b)) nxt = pc + ib;
                7'h6F: begin
                    res = pc + 32'd4;
                    wr  = 1'b1;
                    nxt = pc + ij;
                end
                default: ;
            endcase
            if (wr && (ins[11:7] != 5'd0)) r[ins[11:7]] = res;
            pc = nxt;
        end
    endtask

    task automatic start_reset(input string tag);
        rst_n    = 1'b1;
        load_req = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk({tag, " rst imem_addr"}, imem_addr, 32'd0);
        chk({tag, " rst dmem_we"}, {28'b0, dmem_we}, 32'd0);
        chk({tag, " rst done"}, {31'b0, done_flag}, 32'd0);
        load_req = 1'b0;
        rst_n    = 1'b0;
    endtask

    task automatic run_prog(input string tag);
        int cyc;
        int bad;
        int first;
        model_run();
        start_reset(tag);
        cyc = 0;
        while (!done_flag && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, " done seen"}, {31'b0, done_flag}, 32'd1);
        repeat (6) @(negedge clk);
        chk({tag, " done sticky"}, {31'b0, done_flag}, 32'd1);
        bad   = 0;
        first = -1;
        for (int i = 0; i < 4096; i++) begin
            if (mem[i] !== ref_mem[i]) begin
                bad++;
                if (first < 0) first = i;
            end
        end
        chk($sformatf("%s dmem words differing (first %0d)", tag, first), 32'(bad), 32'd0);
    endtask

    // Reset raised between clock edges must take effect before the next edge
    task automatic async_reset_mid(input string tag, input int cycles);
        repeat (cycles) @(negedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        chk({tag, " async imem_addr"}, imem_addr, 32'd0);
        chk({tag, " async dmem_we"}, {28'b0, dmem_we}, 32'd0);
        chk({tag, " async done"}, {31'b0, done_flag}, 32'd0);
    endtask

    task automatic gen_random(input int n);
        int unsigned sel, t;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        clear_all();
        for (int w = 0; w < 16; w++) dinit[w] = $urandom;
        for (int k = 0; k < n; k++) begin
            sel = $urandom_range(0, 9);
            rd  = 5'($urandom_range(0, 7));
            rs1 = 5'($urandom_range(0, 7));
            rs2 = 5'($urandom_range(0, 7));
            case (sel)
                0, 8: begin
                    t = $urandom_range(0, 4);
                    case (t)
                        0:       emit(enc_r(7'h00, rs2, rs1, 3'b000, rd));
                        1:       emit(enc_r(7'h20, rs2, rs1, 3'b000, rd));
                        2:       emit(enc_r(7'h00, rs2, rs1, 3'b111, rd));
                        3:       emit(enc_r(7'h00, rs2, rs1, 3'b110, rd));
                        default: emit(enc_r(7'h00, rs2, rs1, 3'b010, rd));
                    endcase
                end
                1, 2, 9: begin
                    t = $urandom_range(0, 3);
                    f3 = (t == 0) ? 3'b000 : (t == 1) ? 3'b010 : (t == 2) ? 3'b110 : 3'b111;
                    emit(enc_i(12'($urandom_range(0, 4095)), rs1, f3, rd, 7'b0010011));
                end
                3: emit(lw(rd, 12'(4 * $urandom_range(0, 15))));
                4: emit(enc_s(12'(4 * $urandom_range(16, 31)), rs2, 5'd0));
                5: emit(enc_b(13'(4 * $urandom_range(2, 3)), rs1, ($urandom_range(0, 1) == 1) ? rs1 : rs2));
                6: emit(enc_j(21'(4 * $urandom_range(2, 3)), rd));
                default: emit({20'($urandom), rd, 7'b0110111});
            endcase
        end
        for (int r = 1; r < 8; r++) emit(enc_s(12'(160 + 4 * (r - 1)), 5'(r), 5'd0));
        emit(32'h0000_006F);
    endtask

    initial begin
        rst_n = 1'b1;

        // Back-to-back RAW hazards
        clear_all();
        emit(addi(5'd1, 5'd0, 12'd5));
        emit(addi(5'd2, 5'd1, 12'd3));
        emit(enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3));
        emit(enc_s(12'd0, 5'd2, 5'd0));
        emit(enc_s(12'd4, 5'd3, 5'd0));
        emit(32'h0000_006F);
        run_prog("raw");
        chk("raw dmem0", mem[0], 32'd8);
        chk("raw dmem1", mem[1], 32'd13);
        async_reset_mid("raw", 0);

        // Load-use chain
        clear_all();
        dinit[0] = 32'd7;
        emit(lw(5'd5, 12'd0));
        emit(addi(5'd6, 5'd5, 12'd1));
        emit(addi(5'd7, 5'd6, 12'd2));
        emit(enc_s(12'd4, 5'd6, 5'd0));
        emit(enc_s(12'd8, 5'd7, 5'd0));
        emit(32'h0000_006F);
        run_prog("loaduse");
        chk("loaduse dmem1", mem[1], 32'd8);
        chk("loaduse dmem2", mem[2], 32'd10);

        // Counting loop; exit branch jumps over the x2 increment
        clear_all();
        emit(addi(5'd1, 5'd0, 12'd0));
        emit(addi(5'd2, 5'd0, 12'd0));
        emit(addi(5'd3, 5'd0, 12'd3));
        emit(addi(5'd1, 5'd1, 12'd1));
        emit(enc_b(13'd12, 5'd1, 5'd3));
        emit(enc_b(13'(-8), 5'd0, 5'd0));
        emit(addi(5'd2, 5'd2, 12'd1));
        emit(enc_s(12'd0, 5'd1, 5'd0));
        emit(enc_s(12'd4, 5'd2, 5'd0));
        emit(32'h0000_006F);
        run_prog("loop");
        chk("loop dmem0", mem[0], 32'd3);
        chk("loop dmem1", mem[1], 32'd0);

        // Load feeding store data
        clear_all();
        dinit[0] = 32'hDEAD_BEEF;
        emit(lw(5'd5, 12'd0));
        emit(enc_s(12'd4, 5'd5, 5'd0));
        emit(32'h0000_006F);
        run_prog("lwsw");
        chk("lwsw dmem1", mem[1], 32'hDEAD_BEEF);

        // Not-taken branch, x0 write, unaligned and wrapping store addresses
        clear_all();
        emit(addi(5'd1, 5'd0, 12'd1));
        emit(addi(5'd2, 5'd0, 12'd2));
        emit(enc_b(13'd8, 5'd1, 5'd2));
        emit(addi(5'd3, 5'd0, 12'd5));
        emit(enc_s(12'd0, 5'd3, 5'd0));
        emit(addi(5'd0, 5'd0, 12'd9));
        emit(enc_s(12'd8, 5'd0, 5'd0));
        emit(enc_s(12'd15, 5'd1, 5'd0));
        emit(addi(5'd4, 5'd0, 12'h800));
        emit(enc_s(12'd0, 5'd1, 5'd4));
        emit(32'h0000_006F);
        run_prog("nottaken");
        chk("nottaken dmem0", mem[0], 32'd5);
        chk("nottaken x0 store", mem[2], 32'd0);
        chk("nottaken unaligned store", mem[3], 32'd1);
        chk("nottaken wrapped store", mem[3584], 32'd1);

        for (int k = 0; k < 6; k++) begin
            gen_random(24);
            run_prog($sformatf("rand%0d", k));
        end

        // Reset in the middle of a random program, then a fresh program must run cleanly
        gen_random(24);
        start_reset("midrun");
        async_reset_mid("midrun", int'($urandom_range(6, 30)));
        gen_random(24);
        run_prog("after_midrun");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
